// File: rtl/fft_mag_writer_if.sv
// Bus bundle for the spectrum writer: FFT AXI-Stream input side plus the
// magnitude RAM write port. The writer uses the slave view; the environment uses the master view.
interface fft_mag_writer_if #(
  parameter int ADDR_W = 8
) ();

  logic [31:0]       s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/fft_mag_writer.sv
// Captures the first STORE_BINS bins of one FFT frame, converts each complex bin to an
// alpha-max/beta-min magnitude through a 3-stage pipe, and writes it to the spectrum RAM.
module fft_mag_writer #(
  parameter int FFT_LEN    = 512,
  parameter int STORE_BINS = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  fft_mag_writer_if.slave        bus,
  output logic                   mag_done_o,
  output logic                   frame_err_o
);

  localparam int               CNT_W      = $clog2(FFT_LEN);
  localparam logic [CNT_W-1:0] LAST_BIN   = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_STORE = CNT_W'(STORE_BINS - 1);
  localparam logic [1:0]       FLUSH_LAST = 2'd2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // |v| of a signed 16-bit value, widened so that |-32768| is exact.
  function automatic logic [16:0] abs17(input logic [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    return v[15] ? (17'd0 - ext) : ext;
  endfunction

  logic              accept;
  logic              capture;

  logic [CNT_W-1:0]  bin_cnt_q,   bin_cnt_d;
  logic              frame_err_q, frame_err_d;
  logic [2:0]        state_q,     state_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;

  logic              s1_vld_q;
  logic [ADDR_W-1:0] s1_bin_q;
  logic [16:0]       s1_ar_q;
  logic [16:0]       s1_ai_q;

  logic              s2_vld_q;
  logic [ADDR_W-1:0] s2_bin_q;
  logic [16:0]       s2_mx_q;
  logic [16:0]       s2_mn_q;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;

  // The FFT is never back-pressured; ready only drops while reset is held.
  assign bus.s_axis_tready = ~rst_i;
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin : frame_track
    bin_cnt_d   = bin_cnt_q;
    frame_err_d = frame_err_q;
    if (accept) begin
      if (bus.s_axis_tlast || (bin_cnt_q == LAST_BIN)) begin
        bin_cnt_d = '0;
      end else begin
        bin_cnt_d = bin_cnt_q + 1'b1;
      end
      if (bus.s_axis_tlast && (bin_cnt_q != LAST_BIN)) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_comb begin : capture_fsm
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (accept && (bin_cnt_q == '0)) begin
          capture     = 1'b1;
          flush_cnt_d = '0;
          state_d     = (bin_cnt_q == LAST_STORE) ? ST_FLUSH : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          capture = 1'b1;
          if (bin_cnt_q == LAST_STORE) begin
            flush_cnt_d = '0;
            state_d     = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // One cycle per pipe stage, so DONE coincides with the last write retiring.
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (start_i) state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      // NOTE: the pipe data registers are reset too, so outputs are defined from the first cycle.
      s1_vld_q    <= 1'b0;
      s1_bin_q    <= '0;
      s1_ar_q     <= '0;
      s1_ai_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_bin_q    <= '0;
      s2_mx_q     <= '0;
      s2_mn_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      bin_cnt_q   <= bin_cnt_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;

      s1_vld_q <= capture;
      if (capture) begin
        s1_bin_q <= ADDR_W'(bin_cnt_q);
        s1_ar_q  <= abs17(bus.s_axis_tdata[15:0]);
        s1_ai_q  <= abs17(bus.s_axis_tdata[31:16]);
      end

      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_bin_q <= s1_bin_q;
        s2_mx_q  <= (s1_ar_q >= s1_ai_q) ? s1_ar_q : s1_ai_q;
        s2_mn_q  <= (s1_ar_q >= s1_ai_q) ? s1_ai_q : s1_ar_q;
      end

      // mx + 0.375*mn peaks at 45056, so the 16-bit result never overflows.
      wr_en_q <= s2_vld_q;
      if (s2_vld_q) begin
        wr_addr_q <= s2_bin_q;
        wr_data_q <= 16'(s2_mx_q + (s2_mn_q >> 2) + (s2_mn_q >> 3));
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign mag_done_o  = (state_q == ST_DONE);
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_fft_mag_writer.sv
// Self-checking bench for fft_mag_writer: random FFT stream against a frame-level
// reference model, plus literal expectations for the documented corner values.
module tb_fft_mag_writer;

  localparam int FFT_LEN    = 512;
  localparam int STORE_BINS = 256;
  localparam int ADDR_W     = 8;

  typedef enum {M_IDLE, M_ARMED, M_CAPT, M_FINISH, M_DONE} mphase_t;
  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic clk;
  logic rst;
  logic start;
  logic mag_done;
  logic frame_err;

  fft_mag_writer_if #(.ADDR_W(ADDR_W)) bus ();

  fft_mag_writer #(
    .FFT_LEN   (FFT_LEN),
    .STORE_BINS(STORE_BINS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .bus        (bus),
    .mag_done_o (mag_done),
    .frame_err_o(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Magnitude straight from the arithmetic definition.
  function automatic int mag_of(input int re, input int im);
    int ar, ai, mx, mn;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    return mx + mn / 4 + mn / 8;
  endfunction

  // Reference model and DUT RAM image
  mphase_t  ph      = M_IDLE;
  int       m_pos   = 0;
  bit       m_err   = 1'b0;
  int       done_at = -1;
  int       cyc     = 0;
  wr_t      exp_q[$];
  logic [15:0] ram [STORE_BINS];
  int       wr_count = 0;

  always @(negedge clk) begin
    mphase_t ph0;
    int re, im;
    check("tready", bus.s_axis_tready, !rst);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      check("wr_en", bus.wr_en, 1);
      check("wr_addr", bus.wr_addr, exp_q[0].addr);
      check("wr_data", bus.wr_data, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      check("wr_en_idle", bus.wr_en, 0);
    end
    check("mag_done", mag_done, (ph == M_DONE));
    check("frame_err", frame_err, m_err);

    if (bus.wr_en === 1'b1) begin
      ram[bus.wr_addr] = bus.wr_data;
      wr_count++;
    end

    if (rst) begin
      ph      = M_IDLE;
      m_pos   = 0;
      m_err   = 1'b0;
      done_at = -1;
      exp_q.delete();
    end else begin
      ph0 = ph;
      if (bus.s_axis_tvalid) begin
        re = int'($signed(bus.s_axis_tdata[15:0]));
        im = int'($signed(bus.s_axis_tdata[31:16]));
        if (ph == M_ARMED && m_pos == 0) ph = M_CAPT;
        if (ph == M_CAPT) begin
          exp_q.push_back('{cyc + 3, m_pos, mag_of(re, im)});
          if (m_pos == STORE_BINS - 1) begin
            ph      = M_FINISH;
            done_at = cyc + 4;
          end
        end
        if (bus.s_axis_tlast) begin
          if (m_pos != FFT_LEN - 1) m_err = 1'b1;
          m_pos = 0;
        end else begin
          m_pos = (m_pos + 1) % FFT_LEN;
        end
      end
      if (ph == M_FINISH && cyc + 1 == done_at) ph = M_DONE;
      if (start && (ph0 == M_IDLE || ph0 == M_DONE)) ph = M_ARMED;
    end
    cyc++;
  end

  // Stimulus
  int drv_pos = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_beat(input int re, input int im, input bit short_last);
    bus.s_axis_tdata  = {16'(im), 16'(re)};
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = short_last || (drv_pos == FFT_LEN - 1);
    tick();
    drv_pos = bus.s_axis_tlast ? 0 : drv_pos + 1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  // mode 0: fixed (3000,-4000); 1: random; 2: corner bins at 0..2, random elsewhere
  task automatic send(input int n, input int mode, input int gap_pct, input int short_at);
    int sent, re, im;
    sent = 0;
    while (sent < n) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        idle(1);
      end else begin
        re = int'($urandom_range(65535)) - 32768;
        im = int'($urandom_range(65535)) - 32768;
        if (mode == 0) begin
          re = 3000;
          im = -4000;
        end else if (mode == 2 && drv_pos == 0) begin
          re = -32768;
          im = -32768;
        end else if (mode == 2 && drv_pos == 1) begin
          re = 0;
          im = -1;
        end else if (mode == 2 && drv_pos == 2) begin
          re = 0;
          im = 0;
        end
        drive_beat(re, im, drv_pos == short_at);
        sent++;
      end
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < STORE_BINS; i++) ram[i] = 16'hFFFF;
    wr_count = 0;
  endtask

  initial begin
    int nbad;
    rst = 1'b1;
    start = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    idle(2);

    // T1: reset held 3 cycles in the middle of a capture
    pulse_start();
    send(150, 1, 0, -1);
    rst = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    drv_pos = 0;
    idle(4);
    check("t1_tready", bus.s_axis_tready, 1);
    check("t1_wr_en", bus.wr_en, 0);
    check("t1_done", mag_done, 0);
    check("t1_err", frame_err, 0);

    // T2: full frame of constant bins
    clear_ram();
    pulse_start();
    send(FFT_LEN, 0, 0, -1);
    idle(2);
    check("t2_writes", wr_count, STORE_BINS);
    nbad = 0;
    for (int i = 0; i < STORE_BINS; i++) if (ram[i] !== 16'd5125) nbad++;
    check("t2_bad_words", nbad, 0);
    check("t2_done", mag_done, 1);

    // T3: magnitude corners, restarted from DONE
    clear_ram();
    pulse_start();
    check("t3_done_low", mag_done, 0);
    send(FFT_LEN, 2, 0, -1);
    idle(2);
    check("t3_full_scale", ram[0], 16'hB000);
    check("t3_one", ram[1], 16'd1);
    check("t3_zero", ram[2], 16'd0);
    check("t3_writes", wr_count, STORE_BINS);

    // T4: armed at bin 100, capture waits for the next frame start
    send(100, 1, 0, -1);
    clear_ram();
    pulse_start();
    send(FFT_LEN - 100, 1, 0, -1);
    idle(3);
    check("t4_no_early_writes", wr_count, 0);
    send(FFT_LEN, 1, 0, -1);
    idle(2);
    check("t4_writes", wr_count, STORE_BINS);
    check("t4_done", mag_done, 1);

    // T5: short frame ends at bin 299
    clear_ram();
    pulse_start();
    send(300, 1, 0, 299);
    idle(2);
    check("t5_err", frame_err, 1);
    check("t5_writes", wr_count, STORE_BINS);
    pulse_start();
    send(FFT_LEN, 1, 0, -1);
    idle(2);
    check("t5_err_sticky", frame_err, 1);
    check("t5_writes_after", wr_count, 2 * STORE_BINS);

    // T6: gapped stream, then a restart from DONE
    clear_ram();
    pulse_start();
    send(FFT_LEN, 1, 30, -1);
    idle(2);
    check("t6_writes", wr_count, STORE_BINS);
    check("t6_done", mag_done, 1);
    pulse_start();
    check("t6_done_low", mag_done, 0);
    send(FFT_LEN, 1, 30, -1);
    idle(2);
    check("t6_writes_restart", wr_count, 2 * STORE_BINS);
    check("t6_done_again", mag_done, 1);

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
